// File: rtl/dma_fifo_pkg.sv
// Shared constants and types for the DMA TLP FIFO control slice.
package dma_fifo_pkg;

    localparam int DMA_TLP_W       = 116;
    localparam int DMA_FIFO_AW     = 8;
    localparam int DMA_FIFO_DEPTH  = 256;
    localparam int DMA_FIFO_AFULL  = 240;

    typedef logic [DMA_TLP_W-1:0] tlp_word_t;

endpackage

// File: rtl/dma_fifo_outbuf2.sv
// Two-entry output buffer that turns the one-cycle RAM read latency into a
// first-word-fall-through head. Captured words enter at the tail, the head is
// presented combinationally and leaves on a pop.
module dma_fifo_outbuf2
    import dma_fifo_pkg::*;
#(
    parameter int DATA_W = DMA_TLP_W
)(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              capture_i,
    input  logic [DATA_W-1:0] captureData_i,
    input  logic              pop_i,
    output logic [DATA_W-1:0] headData_o,
    output logic              valid_o,
    output logic [1:0]        bufCount_o,
    output logic [1:0]        bufCountNext_o
);

    logic [DATA_W-1:0] entry_q [2];
    logic              headIdx_q, headIdx_d;
    logic              tailIdx_q, tailIdx_d;
    logic [1:0]        count_q, count_d;
    logic              doPop;

    // Index and occupancy bookkeeping; a simultaneous capture and pop cancel in the count.
    always_comb begin
        doPop     = pop_i & (count_q != 2'd0);
        headIdx_d = headIdx_q ^ doPop;
        tailIdx_d = tailIdx_q ^ capture_i;
        count_d   = count_q + {1'b0, capture_i} - {1'b0, doPop};
    end

    // Occupancy and index registers, cleared so stale entries are discarded on reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            headIdx_q <= 1'b0;
            tailIdx_q <= 1'b0;
            count_q   <= 2'd0;
        end else begin
            headIdx_q <= headIdx_d;
            tailIdx_q <= tailIdx_d;
            count_q   <= count_d;
        end
    end

    // Storage only changes on a capture, so the head stays put while nothing arrives.
    always_ff @(posedge clk_i) begin
        if (capture_i) begin
            entry_q[tailIdx_q] <= captureData_i;
        end
    end

    assign headData_o     = entry_q[headIdx_q];
    assign valid_o        = (count_q != 2'd0);
    assign bufCount_o     = count_q;
    assign bufCountNext_o = count_d;

endmodule

// File: rtl/dma_tlp_fifo_ctrl.sv
// Control for a 256-deep TLP FIFO around an external two-port RAM: write
// pointer, read prefetch into a two-entry buffer, occupancy and almost-full.
module dma_tlp_fifo_ctrl
    import dma_fifo_pkg::*;
#(
    parameter int DATA_W       = DMA_TLP_W,
    parameter int ADDR_W       = DMA_FIFO_AW,
    parameter int DEPTH        = DMA_FIFO_DEPTH,
    parameter int AFULL_THRESH = DMA_FIFO_AFULL
)(
    input  logic              clockCore,
    input  logic              resetCore,
    input  logic              inValid,
    output logic              inReady,
    input  logic [DATA_W-1:0] inData,
    output logic              outValid,
    input  logic              outReady,
    output logic [DATA_W-1:0] outData,
    output logic              ramEnableWrite,
    output logic [ADDR_W-1:0] ramAddressWrite,
    output logic [DATA_W-1:0] ramWriteData,
    output logic              ramEnableRead,
    output logic [ADDR_W-1:0] ramAddressRead,
    input  logic [DATA_W-1:0] ramReadData,
    output logic [ADDR_W:0]   level,
    output logic              almostFull
);

    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] AFULL_C = (ADDR_W+1)'(AFULL_THRESH);

    logic [ADDR_W-1:0] wrPtr_q, wrPtr_d;
    logic [ADDR_W-1:0] rdPtr_q, rdPtr_d;
    logic [ADDR_W:0]   ramCount_q, ramCount_d;
    logic [ADDR_W:0]   level_q, level_d;
    logic              rdInflight_q, rdInflight_d;
    logic              almostFull_q, almostFull_d;

    logic              push;
    logic              pop;
    logic              issue;
    logic              bufValid;
    logic [1:0]        bufCount;
    logic [1:0]        bufCountNext;
    logic [2:0]        pending;
    logic [DATA_W-1:0] bufHead;

    assign inReady  = (ramCount_q < DEPTH_C);
    assign push     = inValid & inReady;
    assign pop      = bufValid & outReady;
    assign pending  = {1'b0, bufCount} + {2'b00, rdInflight_q};

    // Issue a RAM read whenever the buffer plus the read already in flight leaves room, counting a pop this cycle as room.
    always_comb begin
        issue = (ramCount_q != '0) &
                ((pending < 3'd2) | ((pending == 3'd2) & pop));
    end

    // Next-state for pointers, RAM occupancy and the registered level/almost-full view.
    always_comb begin
        wrPtr_d      = wrPtr_q + ADDR_W'(push);
        rdPtr_d      = rdPtr_q + ADDR_W'(issue);
        ramCount_d   = ramCount_q + (ADDR_W+1)'(push) - (ADDR_W+1)'(issue);
        rdInflight_d = issue;
        level_d      = ramCount_d + (ADDR_W+1)'(rdInflight_d) + (ADDR_W+1)'(bufCountNext);
        almostFull_d = (level_d >= AFULL_C);
    end

    // State registers; reset drops the in-flight read so its returning data is never captured.
    always_ff @(posedge clockCore) begin
        if (resetCore) begin
            wrPtr_q      <= '0;
            rdPtr_q      <= '0;
            ramCount_q   <= '0;
            rdInflight_q <= 1'b0;
            level_q      <= '0;
            almostFull_q <= 1'b0;
        end else begin
            wrPtr_q      <= wrPtr_d;
            rdPtr_q      <= rdPtr_d;
            ramCount_q   <= ramCount_d;
            rdInflight_q <= rdInflight_d;
            level_q      <= level_d;
            almostFull_q <= almostFull_d;
        end
    end

    dma_fifo_outbuf2 #(
        .DATA_W (DATA_W)
    ) u_outbuf (
        .clk_i          (clockCore),
        .rst_i          (resetCore),
        .capture_i      (rdInflight_q),
        .captureData_i  (ramReadData),
        .pop_i          (pop),
        .headData_o     (bufHead),
        .valid_o        (bufValid),
        .bufCount_o     (bufCount),
        .bufCountNext_o (bufCountNext)
    );

    assign ramEnableWrite  = push;
    assign ramAddressWrite = wrPtr_q;
    assign ramWriteData    = inData;
    assign ramEnableRead   = issue;
    assign ramAddressRead  = rdPtr_q;
    assign outValid        = bufValid;
    assign outData         = bufHead;
    assign level           = level_q;
    assign almostFull      = almostFull_q;

endmodule

// File: doc/dma_tlp_fifo_ctrl.md
Name: dma_tlp_fifo_ctrl

Overview:
- Control block of a 256x116 synchronous FIFO built around the two-port RAM GenRam2P256D116W.
- Accepts valid/ready write traffic from the upstream TLP assembler and drives the RAM write and read ports.
- Prefetches RAM read data into a 2-entry output buffer, giving a first-word-fall-through valid/ready interface downstream.
- Sustains 1 word/cycle in both directions.

Parameters:
- DATA_W, 116, payload width; must match the RAM width.
- ADDR_W, 8, RAM address width.
- DEPTH, 256, RAM entries; equals 2**ADDR_W.
- AFULL_THRESH, 240, almostFull asserts when level >= this value.

Ports:
- clockCore  in  1  core clock; all logic is on the rising edge.
- resetCore  in  1  synchronous reset, active-high.
- inValid  in  1  upstream word valid.
- inReady  out  1  FIFO can accept a word.
- inData  in  DATA_W  upstream word.
- outValid  out  1  output word valid.
- outReady  in  1  downstream accepts the word.
- outData  out  DATA_W  head word.
- ramEnableWrite  out  1  RAM write enable.
- ramAddressWrite  out  ADDR_W  RAM write address.
- ramWriteData  out  DATA_W  RAM write data.
- ramEnableRead  out  1  RAM read enable.
- ramAddressRead  out  ADDR_W  RAM read address.
- ramReadData  in  DATA_W  RAM read data, valid the cycle after ramEnableRead.
- level  out  ADDR_W+1  total words held: RAM + in flight + buffer (max DEPTH+2).
- almostFull  out  1  level >= AFULL_THRESH.

Behaviour:
- Clocking and reset: one clock, clockCore. resetCore is synchronous and active-high.
- Reset values:
  - wrPtr = 0, rdPtr = 0, ramCount = 0, rdInflight = 0, bufCount = 0.
  - outValid = 0, level = 0, almostFull = 0.
  - inReady = 1 from the first cycle after reset.
  - outData content is don't-care while outValid = 0.
- Write path:
  - push = inValid & inReady, where inReady = (ramCount < DEPTH).
  - ramEnableWrite = push; ramAddressWrite = wrPtr; ramWriteData = inData, all combinational.
  - wrPtr increments on push and wraps 255 -> 0.
- Read issue:
  - pop = outValid & outReady.
  - ramEnableRead = (ramCount > 0) & ((bufCount + rdInflight) < 2 | ((bufCount + rdInflight) == 2 & pop)).
  - ramAddressRead = rdPtr; rdPtr increments on issue and wraps.
  - rdInflight <= ramEnableRead.
- Buffer:
  - When rdInflight = 1, ramReadData is written into the 2-entry buffer tail at the next edge.
  - outData = buffer head; outValid = (bufCount > 0).
  - A pop and a capture in the same cycle leave bufCount unchanged and preserve order.
- ramCount update: +1 on push, -1 on read issue; push and issue together leave it unchanged.
- Read/write collision: the same address is never read and written in one cycle. An issue requires ramCount > 0 and a write requires ramCount < DEPTH, so rdPtr != wrPtr whenever both are active. No RAM read-during-write mode is relied on.
- Latency: a push on an empty FIFO at edge t gives read issue at edge t+1, capture at edge t+2, and outValid = 1 in the cycle after t+2. Fall-through latency is 2 cycles.
- Full: capacity is DEPTH+2 = 258 words. inReady drops when ramCount = 256. An upstream word held with inValid while inReady = 0 must be held unchanged until accepted.
- Empty: outValid = 0; outData does not change when no capture occurs.
- level and almostFull are registered and updated on the same edge as the counters.
- Reset mid-operation: all contents are discarded and pointers return to 0. A read in flight is dropped; ramReadData arriving in the cycle after reset is ignored.
- Errors: no overflow or underflow is possible through the handshakes. A bench assertion flags push while inReady = 0 and pop while outValid = 0.

Decomposition:
- Package dma_fifo_pkg holds:
  - constants DMA_TLP_W = 116, DMA_FIFO_AW = 8, DMA_FIFO_DEPTH = 256;
  - typedef tlp_word_t (logic [115:0]).
- Sub-module dma_fifo_outbuf2: 2-entry output buffer with capture, pop, bufCount and head/tail indices.
- The top level holds pointers, ramCount, read-issue logic and level.
- The RAM itself is instantiated by the parent, not inside this block.

Test Plan:
- Single word: after reset, push 0x1 with outReady = 1 -> outValid = 1 two cycles after the push edge, outData = 0x1, level goes 1 -> 0 after the pop.
- Streaming: push 1000 incrementing words with inValid and outReady held high -> after the initial 2-cycle latency, one word out per cycle, in order, no bubbles; level stays <= 3.
- Fill to full: outReady = 0, push until inReady = 0 -> exactly 258 words accepted, level = 258, almostFull has been 1 since level reached 240. Drain -> words 0..257 emerge in order.
- Wrap-around: repeat fill and drain with random outReady (50%) across 3 pointer wraps -> no loss, duplication or reordering; ramAddressRead never equals ramAddressWrite while both enables are high.
- Reset mid-operation: with level = 100 and a read in flight, assert resetCore for 1 cycle -> next cycle outValid = 0, level = 0, inReady = 1. Push 0xABC -> 0xABC is the first word out.
- Held backpressure: outReady = 0 for 20 cycles with 5 words queued -> outData holds word 0 steady, bufCount = 2, no further reads issued; releasing outReady delivers words 0..4 consecutively.
